cmp_window_stats: RTL and testbench
===================================

Name: cmp_window_stats

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Takes a stream of operand pairs (a, b) and the comparator's three result flags (a_gt_b, a_eq_b, a_ls_b), and accumulates per-window statistics.
- Per window it reports the gt/eq/ls outcome counts, the largest operand seen, and a malformed-flag count.
- A window is closed by in_last; the report is then held on a valid/ready output until consumed.

Parameters:
- WIDTH, 4, operand width of a, b and max_val
- CNT_W, 8, width of every outcome counter; counters saturate at 2^CNT_W-1

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample present on a/b/flags
- in_ready  output  1  block accepts a sample this cycle
- in_last  input  1  qualifies the final sample of a window
- a  input  WIDTH  operand a as fed to the comparator
- b  input  WIDTH  operand b as fed to the comparator
- a_gt_b  input  1  comparator flag
- a_eq_b  input  1  comparator flag
- a_ls_b  input  1  comparator flag
- out_valid  output  1  window report valid
- out_ready  input  1  consumer takes the report
- gt_cnt  output  CNT_W  count of a_gt_b samples in the window
- eq_cnt  output  CNT_W  count of a_eq_b samples
- ls_cnt  output  CNT_W  count of a_ls_b samples
- bad_cnt  output  CNT_W  count of samples whose flags are not one-hot
- max_val  output  WIDTH  largest of all a and b values in the window

Behaviour:
- Reset (rst_n=0, async):
  - state=ACCUM; all counters and max_val = 0; out_valid=0; in_ready=1.
  - A reset mid-window or mid-report discards everything; no partial report is emitted.
- FSM states: ACCUM, REPORT.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A sample is accepted when in_valid && in_ready at a rising clk edge.
- Accepted sample with exactly one flag high: increment the matching counter (gt/eq/ls).
- Accepted sample with zero or more than one flag high: increment bad_cnt only; gt/eq/ls are unchanged.
- Larger operand of a sample:
  - a if a_gt_b or a_eq_b is set, otherwise b, for a one-hot sample.
  - For a bad sample, the larger of a and b computed internally.
  - max_val <= max(max_val, larger operand).
  - First sample of a window compares against 0.
- Counter saturation: a counter at 2^CNT_W-1 holds and does not wrap; other counters keep counting.
- Accepted sample with in_last=1:
  - Counters and max_val include that sample.
  - Next state is REPORT; out_valid=1 and in_ready=0 from the next cycle (1-cycle latency from last beat to report).
- REPORT:
  - Outputs are stable and out_valid stays high until out_ready=1.
  - in_valid is ignored while in_ready=0.
  - On out_valid && out_ready: next cycle all counters and max_val = 0, state=ACCUM, in_ready=1.
  - No sample is accepted in the handshake cycle; the earliest next acceptance is the cycle after.
- in_last without in_valid: no effect.
- Windows are never empty; a window always contains at least its last beat.
- Outputs are registered in both states; in ACCUM they expose the running partial values, meaningful only when out_valid=1.
- Output widths are exact: no sign extension, values unsigned.

Decomposition:
- Shared package (cmp_pkg):
  - WIDTH and CNT_W defaults.
  - State encoding enum {ACCUM, REPORT}.
  - Function onehot3(gt,eq,ls).
- One natural sub-module: sat_counter (CNT_W, inc, clr, count), instanced four times.
- FSM and max tracking stay in the top.

Test Plan:
- Reset mid-window: 3 samples accepted, then rst_n pulsed low -> all counts 0, max_val=0, out_valid=0, in_ready=1 immediately (async).
- Window of 4: (1,0,gt),(2,3,ls),(5,5,eq),(7,6,gt,last) -> one cycle later out_valid=1, gt_cnt=2, ls_cnt=1, eq_cnt=1, bad_cnt=0, max_val=7; in_ready=0.
- Backpressure: out_ready held 0 for 5 cycles with in_valid=1 -> report stable, no sample counted. out_ready=1 -> next cycle in_ready=1, counts 0. Next window (15,1,gt,last) -> gt_cnt=1, max_val=15.
- Bad flags: (3,4,gt=1,ls=1), (0,15,all 0,last) -> bad_cnt=2, gt/eq/ls=0, max_val=15.
- Saturation with CNT_W=2: 5 eq samples (8,8), last on the 5th -> eq_cnt=3, max_val=8.
- Single-sample window (0,15,ls,last) -> ls_cnt=1, max_val=15. Back-to-back windows with out_ready tied 1 -> one report per window, no lost or double-counted samples.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator window statistics block:
// default widths, FSM state encoding and the flag validity helper.
package cmp_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    // Exactly one of the three comparator flags is set: odd parity rules out
    // zero and two, and the AND term rules out all three.
    function automatic logic onehot3(input logic gt, input logic eq, input logic ls);
        return (gt ^ eq ^ ls) && !(gt && eq && ls);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cmp_window_stats.sv
// Accumulates per-window outcome counts and the largest operand of a stream
// of comparator results, then holds the report on a valid/ready output.
module cmp_window_stats
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_ls_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] ls_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [WIDTH-1:0] max_val
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             fire;
    logic             onehot;
    logic [WIDTH-1:0] larger;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == REPORT);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign onehot    = onehot3(a_gt_b, a_eq_b, a_ls_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && in_last) state_nxt = REPORT;
            REPORT:  if (out_ready)         state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Trust the comparator when its flags are coherent; otherwise work the
    // larger operand out locally.
    always_comb begin
        larger = b;
        if (onehot) begin
            if (a_gt_b || a_eq_b) larger = a;
        end else if (a > b) begin
            larger = a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
        end else if (fire) begin
            max_val <= '0;
        end else if (accept && (larger > max_val)) begin
            max_val <= larger;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && onehot && a_gt_b),
        .clr   (fire),
        .count (gt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_eq (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && onehot && a_eq_b),
        .clr   (fire),
        .count (eq_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ls (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && onehot && a_ls_b),
        .clr   (fire),
        .count (ls_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bad (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && !onehot),
        .clr   (fire),
        .count (bad_cnt)
    );

endmodule

// File: tb/tb_cmp_window_stats.sv
// Directed bench for cmp_window_stats: a wide-counter instance and a 2-bit
// counter instance share one stimulus stream and are checked side by side.
module tb_cmp_window_stats;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [3:0] a, b;
    logic       a_gt_b, a_eq_b, a_ls_b;

    logic       in_ready, out_valid;
    logic [7:0] gt_cnt, eq_cnt, ls_cnt, bad_cnt;
    logic [3:0] max_val;

    logic       s_in_ready, s_out_valid;
    logic [1:0] s_gt_cnt, s_eq_cnt, s_ls_cnt, s_bad_cnt;
    logic [3:0] s_max_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       gt, eq, ls, last;
        int         e_gt, e_eq, e_ls, e_bad, e_max;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cmp_window_stats #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .a(a), .b(b), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
        .a_ls_b(a_ls_b), .out_valid(out_valid), .out_ready(out_ready),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .ls_cnt(ls_cnt), .bad_cnt(bad_cnt),
        .max_val(max_val)
    );

    cmp_window_stats #(.WIDTH(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .a(a), .b(b), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
        .a_ls_b(a_ls_b), .out_valid(s_out_valid), .out_ready(out_ready),
        .gt_cnt(s_gt_cnt), .eq_cnt(s_eq_cnt), .ls_cnt(s_ls_cnt), .bad_cnt(s_bad_cnt),
        .max_val(s_max_val)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic vec_t mk(input int va, input int vb, input logic g, input logic e,
                                input logic l, input logic lst, input int xg, input int xe,
                                input int xl, input int xb, input int xm);
        vec_t v;
        v.a = 4'(va); v.b = 4'(vb); v.gt = g; v.eq = e; v.ls = l; v.last = lst;
        v.e_gt = xg; v.e_eq = xe; v.e_ls = xl; v.e_bad = xb; v.e_max = xm;
        return v;
    endfunction

    task automatic drive(input int va, input int vb, input logic g, input logic e,
                         input logic l, input logic lst, input logic vld);
        a = 4'(va); b = 4'(vb); a_gt_b = g; a_eq_b = e; a_ls_b = l;
        in_last = lst; in_valid = vld;
    endtask

    task automatic check_report(input string tag, input int xg, input int xe,
                                input int xl, input int xb, input int xm);
        check({tag, " out_valid"}, int'(out_valid), 1);
        check({tag, " in_ready"},  int'(in_ready), 0);
        check({tag, " gt_cnt"},    int'(gt_cnt), xg);
        check({tag, " eq_cnt"},    int'(eq_cnt), xe);
        check({tag, " ls_cnt"},    int'(ls_cnt), xl);
        check({tag, " bad_cnt"},   int'(bad_cnt), xb);
        check({tag, " max_val"},   int'(max_val), xm);
        check({tag, " s_out_valid"}, int'(s_out_valid), 1);
        check({tag, " s_gt_cnt"},  int'(s_gt_cnt), sat3(xg));
        check({tag, " s_eq_cnt"},  int'(s_eq_cnt), sat3(xe));
        check({tag, " s_ls_cnt"},  int'(s_ls_cnt), sat3(xl));
        check({tag, " s_bad_cnt"}, int'(s_bad_cnt), sat3(xb));
        check({tag, " s_max_val"}, int'(s_max_val), xm);
    endtask

    task automatic check_clear(input string tag);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " in_ready"},  int'(in_ready), 1);
        check({tag, " counts"},    int'(gt_cnt) + int'(eq_cnt) + int'(ls_cnt) + int'(bad_cnt), 0);
        check({tag, " max_val"},   int'(max_val), 0);
        check({tag, " s_counts"},  int'(s_gt_cnt) + int'(s_eq_cnt) + int'(s_ls_cnt) + int'(s_bad_cnt), 0);
        check({tag, " s_in_ready"}, int'(s_in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Windows: 4-beat mixed, bad flags, single beat, 5 eq beats (saturates CNT_W=2).
        vecs.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 3, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(5, 5, 0, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(7, 6, 1, 0, 0, 1,  2, 1, 1, 0, 7));
        vecs.push_back(mk(3, 4, 1, 0, 1, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 15, 0, 0, 0, 1, 0, 0, 0, 2, 15));
        vecs.push_back(mk(0, 15, 0, 0, 1, 1, 0, 0, 1, 0, 15));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(8, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8, 8, 0, 1, 0, 1,  0, 5, 0, 0, 8));

        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check_clear("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-window: three beats accepted, then an async reset pulse.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(9 + k, 2, 1, 0, 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_clear("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven windows, one report handshake per window.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].eq, vecs[i].ls, vecs[i].last, 1);
            @(posedge clk);
            if (vecs[i].last) begin
                @(negedge clk);
                in_valid = 1'b0;
                check_report($sformatf("win%0d", i), vecs[i].e_gt, vecs[i].e_eq,
                             vecs[i].e_ls, vecs[i].e_bad, vecs[i].e_max);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check_clear($sformatf("clr%0d", i));
            end
        end

        // Backpressure: report held for 5 cycles while in_valid stays high.
        @(negedge clk);
        drive(4, 2, 1, 0, 0, 1, 1);
        @(negedge clk);
        drive(9, 9, 0, 1, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            check_report($sformatf("bp%0d", k), 1, 0, 0, 0, 4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_clear("bp_release");
        drive(15, 1, 1, 0, 0, 1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check_report("bp_next", 1, 0, 0, 0, 15);
        out_ready = 1'b1;
        @(negedge clk);

        // in_last without in_valid has no effect.
        drive(6, 1, 1, 0, 0, 1, 0);
        @(negedge clk);
        check_clear("last_novalid");

        // Back-to-back windows with out_ready tied high.
        drive(1, 2, 0, 0, 1, 1, 1);
        @(negedge clk);
        check_report("b2b0", 0, 0, 1, 0, 2);
        drive(3, 3, 0, 1, 0, 1, 1);
        @(negedge clk);
        check_clear("b2b_gap");
        @(negedge clk);
        check_report("b2b1", 0, 1, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_clear("b2b_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
